// File: rtl/f_pc_select.sv
// f_pc_select: fetch-stage PC selection and next-PC prediction for a Y86-style pipeline.
// Optional feature: define RAS_EN to add a 4-entry circular return-address stack that
// predicts RET targets. The default build has no stack, and every RET in write-back
// redirects fetch.

`ifndef RSTENABLE
`define RSTENABLE 1'b1
`endif
`ifndef NIBBLE
`define NIBBLE 3:0
`endif
`ifndef WORD
`define WORD 31:0
`endif
`ifndef IRMOVL
`define IRMOVL 4'h3
`endif
`ifndef JXX
`define JXX 4'h7
`endif
`ifndef CALL
`define CALL 4'h8
`endif
`ifndef RET
`define RET 4'h9
`endif

module f_pc_select (
  input  logic           clk,
  input  logic           rst,
  input  logic           F_stall_i,
  input  logic [`NIBBLE] f_icode_i,
  input  logic [`WORD]   f_valC_i,
  input  logic [`WORD]   f_valP_i,
  input  logic [`NIBBLE] M_icode_i,
  input  logic           M_Cnd_i,
  input  logic [`WORD]   M_valA_i,
  input  logic [`NIBBLE] W_icode_i,
  input  logic [`WORD]   W_valM_i,
  output logic [`WORD]   f_pc_o,
  output logic [`WORD]   F_predPC_o,
  output logic           f_ret_pred_o
);

  logic [`WORD] predPC_q;
  logic [`WORD] predPC_d;
  logic         corrDue;
  logic         rasHit;
  logic [`WORD] rasTop;

`ifdef RAS_EN
  logic [`WORD] rasMem_q [4];
  logic [1:0]   rasPtr_q;
  logic [1:0]   rasPtr_d;
  logic [2:0]   rasCount_q;
  logic [2:0]   rasCount_d;
  logic [`WORD] ret_pred_q;
  logic [`WORD] ret_pred_d;
  logic         ras_used_q;
  logic         ras_used_d;
  logic         rasPush;

  // The entry below the pointer is the most recent push; a hit requires a live entry and an advancing fetch.
  assign rasTop  = rasMem_q[rasPtr_q - 2'd1];
  assign rasHit  = (f_icode_i == `RET) && (rasCount_q != 3'd0) && !F_stall_i && (rst != `RSTENABLE);
  assign rasPush = (f_icode_i == `CALL) && !F_stall_i;
  // A write-back RET needs a redirect unless its target was predicted from the stack and matches.
  assign corrDue = (W_icode_i == `RET) && (!ras_used_q || (W_valM_i != ret_pred_q));

  // Stack bookkeeping; a correction flushes the stack even when a CALL pushes in the same cycle.
  always_comb begin
    rasPtr_d   = rasPtr_q;
    rasCount_d = rasCount_q;
    ret_pred_d = ret_pred_q;
    ras_used_d = ras_used_q;
    if (!F_stall_i) begin
      if (rasHit) begin
        ret_pred_d = rasTop;
      end
      if (corrDue) begin
        rasCount_d = 3'd0;
        ras_used_d = 1'b0;
      end else if (rasPush) begin
        rasPtr_d   = rasPtr_q + 2'd1;
        rasCount_d = (rasCount_q == 3'd4) ? 3'd4 : rasCount_q + 3'd1;
      end else if (rasHit) begin
        rasPtr_d   = rasPtr_q - 2'd1;
        rasCount_d = rasCount_q - 3'd1;
        ras_used_d = 1'b1;
      end
    end
  end

  // Stack control registers; reset empties the stack and forgets any outstanding prediction.
  always_ff @(posedge clk) begin
    if (rst == `RSTENABLE) begin
      rasPtr_q   <= 2'd0;
      rasCount_q <= 3'd0;
      ret_pred_q <= '0;
      ras_used_q <= 1'b0;
    end else begin
      rasPtr_q   <= rasPtr_d;
      rasCount_q <= rasCount_d;
      ret_pred_q <= ret_pred_d;
      ras_used_q <= ras_used_d;
    end
  end

  // Stack storage needs no reset; a full push wraps onto the oldest entry.
  always_ff @(posedge clk) begin
    if ((rst != `RSTENABLE) && rasPush && !corrDue) begin
      rasMem_q[rasPtr_q] <= f_valP_i;
    end
  end

  assign f_ret_pred_o = rasHit;
`else
  assign rasTop       = '0;
  assign rasHit       = 1'b0;
  assign corrDue      = (W_icode_i == `RET);
  assign f_ret_pred_o = 1'b0;
`endif

  // Fetch PC: a mispredicted branch outranks a RET redirect, which outranks the prediction.
  always_comb begin
    f_pc_o = predPC_q;
    if ((M_icode_i == `JXX) && !M_Cnd_i) begin
      f_pc_o = M_valA_i;
    end else if (corrDue) begin
      f_pc_o = W_valM_i;
    end
  end

  // Next prediction: taken-branch/call targets, stack top for predicted RETs, else fall-through.
  always_comb begin
    predPC_d = f_valP_i;
    if ((f_icode_i == `JXX) || (f_icode_i == `CALL)) begin
      predPC_d = f_valC_i;
    end else if (rasHit) begin
      predPC_d = rasTop;
    end
  end

  // Predicted-PC register; reset outranks the stall.
  always_ff @(posedge clk) begin
    if (rst == `RSTENABLE) begin
      predPC_q <= '0;
    end else if (!F_stall_i) begin
      predPC_q <= predPC_d;
    end
  end

  assign F_predPC_o = predPC_q;

endmodule

// File: doc/f_pc_select.md
F_PC_SELECT -- requirements
Module: f_pc_select

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst (rst==`RSTENABLE` resets on the rising edge of clk).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 F_stall_i  input  1  hold the F register this cycle.
REQ-005 f_icode_i  input  `NIBBLE  icode of the instruction currently being fetched (from the fetch decode stage).
REQ-006 f_valC_i  input  `WORD  constant word of the fetched instruction.
REQ-007 f_valP_i  input  `WORD  sequential next PC of the fetched instruction.
REQ-008 M_icode_i, M_Cnd_i, M_valA_i  input  `NIBBLE/1/`WORD  memory-stage icode, branch condition, and fall-through PC.
REQ-009 W_icode_i, W_valM_i  input  `NIBBLE/`WORD  write-back-stage icode and loaded return address.
REQ-010 f_pc_o  output  `WORD  PC presented to instruction memory and the fetch decode stage.
REQ-011 F_predPC_o  output  `WORD  current contents of the predicted-PC register.
REQ-012 f_ret_pred_o  output  1  the current RET is predicted from the return stack (RAS build only; constant 0 otherwise).

Function
REQ-013 f_pc_o SHALL be combinational, with this priority:
- M_icode_i==`JXX` and M_Cnd_i==0 -> M_valA_i.
- Otherwise, W_icode_i==`RET` with a correction due (REQ-021) -> W_valM_i.
- Otherwise -> F_predPC.
REQ-014 Without RAS, any W_icode_i==`RET` SHALL count as a correction due.
REQ-015 Next prediction:
- f_icode_i in {`JXX`, `CALL`} -> f_valC_i.
- f_icode_i==`RET` with RAS hit -> top of stack.
- Otherwise -> f_valP_i.
REQ-016 F_predPC SHALL load the next prediction on every rising edge where F_stall_i==0, and hold when F_stall_i==1.
REQ-017 The path from f_pc_o to F_predPC has 1-cycle latency; no combinational path SHALL exist from F_predPC inputs back to f_pc_o except through the register.
REQ-018 All additions and selections are 32-bit; no carry or overflow handling (wrap modulo 2^32).

Reset
REQ-019 On reset the block SHALL set F_predPC=32'h00000000, RAS count=0, RAS pointer=0, ret_pred_q=0, ras_used_q=0, and f_ret_pred_o=0.
REQ-020 Reset SHALL override F_stall_i. During a reset cycle f_pc_o follows REQ-013 combinationally; after reset f_pc_o==0 unless an M/W redirect is present.

Configuration
REQ-021 Macro RAS_EN SHALL build in a 4-entry circular return-address stack:
- Push f_valP_i when f_icode_i==`CALL` and F_stall_i==0.
- Pop when f_icode_i==`RET`, count>0, and F_stall_i==0; this is a RAS hit, and f_ret_pred_o=1.
- On a hit, also latch the popped value into ret_pred_q and set ras_used_q.
- A correction is due when W_icode_i==`RET` and either ras_used_q==0 or W_valM_i!=ret_pred_q.
- On a correction, clear count to 0 and clear ras_used_q.
REQ-022 RAS boundary behaviour:
- Push when full overwrites the oldest entry; count saturates at 4.
- RET with count==0 is not a hit; prediction is f_valP_i and f_ret_pred_o=0.
- A push and a correction in the same cycle: the correction wins, leaving count=0.
- A stall freezes the stack, ret_pred_q, and ras_used_q.
REQ-023 Without RAS_EN the stack logic SHALL be absent, f_ret_pred_o SHALL be tied to 0, and REQ-014 applies.

Verification
REQ-024 Reset with F_stall_i=1 and no redirects -> after the edge, F_predPC_o=0 and f_pc_o=0.
REQ-025 f_icode_i=`JXX`, f_valC_i=32'h40, f_valP_i=32'h15 -> after the edge, F_predPC_o=32'h40. The next cycle with M_icode_i=`JXX`, M_Cnd_i=0, M_valA_i=32'h15 -> f_pc_o=32'h15, overriding a simultaneous W RET.
REQ-026 F_stall_i=1 with f_icode_i=`IRMOVL`, f_valP_i=32'h26 -> F_predPC_o unchanged over 3 cycles; it loads 32'h26 on the first unstalled edge.
REQ-027 RAS_EN build: CALL with f_valP_i=32'h105, then RET -> f_ret_pred_o=1 and next F_predPC_o=32'h105. W RET with W_valM_i=32'h105 -> no redirect. W RET with W_valM_i=32'h200 -> f_pc_o=32'h200 and stack emptied.
REQ-028 RAS_EN build: 5 CALLs with f_valP_i=32'h11..32'h15, then 5 RETs -> predictions 15, 14, 13, 12, then f_valP_i with f_ret_pred_o=0 on the fifth RET.
REQ-029 Build without RAS_EN: RET fetched -> F_predPC_o=f_valP_i and f_ret_pred_o=0. W RET with W_valM_i=32'h80 -> f_pc_o=32'h80.
